// File: rtl/wave_analyzer.sv
// wave_analyzer: per-cycle waveform measurement on an unsigned sample stream.
// A rising threshold crossing marks the start of each waveform cycle. Between two
// crossings the block counts samples, tracks peak/trough and counts high samples.
// On a crossing the finished cycle is latched into pending registers and a
// restoring divider computes SAMPLE_RATE/period. Measurement continues while the
// divider runs.
module wave_analyzer #(
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned BIT_DEPTH   = 24,
    parameter int unsigned MAX_PERIOD  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic [31:0] sample_i,
    input  logic        sample_valid_i,
    input  logic [31:0] threshold_i,
    output logic [31:0] period_o,
    output logic [31:0] freq_o,
    output logic [31:0] peak_o,
    output logic [31:0] trough_o,
    output logic [31:0] high_cnt_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic        no_signal_o,
    output logic        overrun_o
);

    // Only the low BIT_DEPTH bits of samples and threshold carry information.
    localparam logic [63:0] MaskWide   = (64'd1 << BIT_DEPTH) - 64'd1;
    localparam logic [31:0] SampleMask = MaskWide[31:0];
    localparam logic [31:0] MaxPeriod  = 32'(MAX_PERIOD);
    localparam logic [31:0] SampleRate = 32'(SAMPLE_RATE);

    typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;
    typedef enum logic {DivIdle, DivRun} div_state_e;

    state_e      state_q;
    div_state_e  div_state_q;
    logic        prev_above_q;

    // Running measurement of the current waveform cycle.
    logic [31:0] cnt_q;
    logic [31:0] peak_q;
    logic [31:0] trough_q;
    logic [31:0] hc_q;

    // Pending result, isolated from the running counters while the divide runs.
    logic [31:0] pend_period_q;
    logic [31:0] pend_peak_q;
    logic [31:0] pend_trough_q;
    logic [31:0] pend_hc_q;

    // Restoring divider state.
    logic [32:0] div_rem_q;
    logic [31:0] div_quo_q;
    logic [31:0] div_dvd_q;
    logic [4:0]  div_iter_q;

    logic [31:0] smp;
    logic [31:0] thr;
    logic        above;
    logic        crossing;
    logic [31:0] peak_upd;
    logic [31:0] trough_upd;
    logic [32:0] rem_shift;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic        rem_ge;

    // Sample qualification, crossing detection and running min/max candidates.
    always_comb begin
        smp        = sample_i & SampleMask;
        thr        = threshold_i & SampleMask;
        above      = (smp >= thr);
        crossing   = sample_valid_i & above & ~prev_above_q;
        peak_upd   = (smp > peak_q) ? smp : peak_q;
        trough_upd = (smp < trough_q) ? smp : trough_q;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if possible.
    always_comb begin
        rem_shift = {div_rem_q[31:0], div_dvd_q[31]};
        rem_ge    = (rem_shift >= {1'b0, pend_period_q});
        rem_next  = rem_ge ? (rem_shift - {1'b0, pend_period_q}) : rem_shift;
        quo_next  = {div_quo_q[30:0], rem_ge};
    end

    assign busy_o = (div_state_q == DivRun);

    // Main FSM, divider sequencing and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            div_state_q    <= DivIdle;
            prev_above_q   <= 1'b1;
            cnt_q          <= '0;
            peak_q         <= '0;
            trough_q       <= '0;
            hc_q           <= '0;
            pend_period_q  <= '0;
            pend_peak_q    <= '0;
            pend_trough_q  <= '0;
            pend_hc_q      <= '0;
            div_rem_q      <= '0;
            div_quo_q      <= '0;
            div_dvd_q      <= '0;
            div_iter_q     <= '0;
            period_o       <= '0;
            freq_o         <= '0;
            peak_o         <= '0;
            trough_o       <= '0;
            high_cnt_o     <= '0;
            result_valid_o <= 1'b0;
            no_signal_o    <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            if (sample_valid_i) begin
                prev_above_q <= above;
            end

            if (!enable_i) begin
                // Abort everything; published results are left untouched.
                state_q     <= StIdle;
                div_state_q <= DivIdle;
                div_iter_q  <= '0;
                cnt_q       <= '0;
                peak_q      <= '0;
                trough_q    <= '0;
                hc_q        <= '0;
            end else begin
                if (div_state_q == DivRun) begin
                    div_rem_q  <= rem_next;
                    div_quo_q  <= quo_next;
                    div_dvd_q  <= {div_dvd_q[30:0], 1'b0};
                    div_iter_q <= div_iter_q + 5'd1;
                    if (div_iter_q == 5'd31) begin
                        div_state_q    <= DivIdle;
                        period_o       <= pend_period_q;
                        freq_o         <= quo_next;
                        peak_o         <= pend_peak_q;
                        trough_o       <= pend_trough_q;
                        high_cnt_o     <= pend_hc_q;
                        no_signal_o    <= 1'b0;
                        result_valid_o <= 1'b1;
                    end
                end

                case (state_q)
                    StIdle: begin
                        cnt_q     <= '0;
                        peak_q    <= '0;
                        trough_q  <= '0;
                        hc_q      <= '0;
                        overrun_o <= 1'b0;
                        state_q   <= StArm;
                    end
                    StArm: begin
                        if (crossing) begin
                            cnt_q    <= 32'd1;
                            peak_q   <= smp;
                            trough_q <= smp;
                            hc_q     <= 32'd1;
                            state_q  <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        if (crossing) begin
                            if (div_state_q == DivIdle) begin
                                pend_period_q <= cnt_q;
                                pend_peak_q   <= peak_q;
                                pend_trough_q <= trough_q;
                                pend_hc_q     <= hc_q;
                                div_state_q   <= DivRun;
                                div_rem_q     <= '0;
                                div_quo_q     <= '0;
                                div_dvd_q     <= SampleRate;
                                div_iter_q    <= '0;
                            end else begin
                                // Previous result still dividing: drop this cycle.
                                overrun_o <= 1'b1;
                            end
                            cnt_q    <= 32'd1;
                            peak_q   <= smp;
                            trough_q <= smp;
                            hc_q     <= 32'd1;
                        end else if (sample_valid_i) begin
                            if (cnt_q == MaxPeriod) begin
                                // No crossing within MAX_PERIOD samples: report no signal.
                                period_o       <= '0;
                                freq_o         <= '0;
                                peak_o         <= peak_q;
                                trough_o       <= trough_q;
                                high_cnt_o     <= hc_q;
                                no_signal_o    <= 1'b1;
                                result_valid_o <= 1'b1;
                                state_q        <= StArm;
                            end else begin
                                cnt_q    <= cnt_q + 32'd1;
                                peak_q   <= peak_upd;
                                trough_q <= trough_upd;
                                hc_q     <= hc_q + {31'd0, above};
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_analyzer.sv
// tb_wave_analyzer: table-driven periodic waves plus hand-written overrun,
// timeout, abort and reset sequences. Expected results are queued when the
// crossing sample is driven and compared when result_valid_o pulses.
module tb_wave_analyzer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [31:0] sample_i;
    logic        sample_valid_i;
    logic [31:0] threshold_i;
    logic [31:0] period_o;
    logic [31:0] freq_o;
    logic [31:0] peak_o;
    logic [31:0] trough_o;
    logic [31:0] high_cnt_o;
    logic        result_valid_o;
    logic        busy_o;
    logic        no_signal_o;
    logic        overrun_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] period;
        logic [31:0] freq;
        logic [31:0] peak;
        logic [31:0] trough;
        logic [31:0] hc;
        logic        nosig;
    } exp_t;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] step;
        logic [31:0] thr;
        int          len;
        int          ic;
        int          gap;
        bit          junk;
        logic [31:0] period;
        logic [31:0] freq;
        logic [31:0] peak;
        logic [31:0] trough;
        logic [31:0] hc;
    } vec_t;

    exp_t q[$];
    exp_t none;
    vec_t vecs[5];

    wave_analyzer #(
        .SAMPLE_RATE(48000),
        .BIT_DEPTH  (24),
        .MAX_PERIOD (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .sample_i      (sample_i),
        .sample_valid_i(sample_valid_i),
        .threshold_i   (threshold_i),
        .period_o      (period_o),
        .freq_o        (freq_o),
        .peak_o        (peak_o),
        .trough_o      (trough_o),
        .high_cnt_o    (high_cnt_o),
        .result_valid_o(result_valid_o),
        .busy_o        (busy_o),
        .no_signal_o   (no_signal_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [31:0] p, input logic [31:0] f, input logic [31:0] pk,
                                input logic [31:0] tr, input logic [31:0] hc, input logic ns);
        exp_t e;
        e.cyc = 0; e.period = p; e.freq = f; e.peak = pk; e.trough = tr; e.hc = hc; e.nosig = ns;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e);
        check({tag, ".period"}, period_o, e.period);
        check({tag, ".freq"}, freq_o, e.freq);
        check({tag, ".peak"}, peak_o, e.peak);
        check({tag, ".trough"}, trough_o, e.trough);
        check({tag, ".high_cnt"}, high_cnt_o, e.hc);
        check({tag, ".no_signal"}, {31'd0, no_signal_o}, {31'd0, e.nosig});
    endtask

    // Drive one valid sample, optionally queue the result it should produce after lat clocks.
    task automatic send(input logic [31:0] v, input int gap, input bit push, input int lat,
                        input exp_t e);
        exp_t ee;
        ee = e;
        @(negedge clk);
        sample_i       = v;
        sample_valid_i = 1'b1;
        if (push) begin
            ee.cyc = cyc + lat;
            q.push_back(ee);
        end
        for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            sample_valid_i = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sample_valid_i = 1'b0;
        end
    endtask

    task automatic rearm(input logic [31:0] thr);
        @(negedge clk);
        sample_valid_i = 1'b0;
        enable_i       = 1'b0;
        idle(2);
        threshold_i = thr;
        enable_i    = 1'b1;
        idle(1);
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation, on time.
    always @(negedge clk) begin
        if (result_valid_o) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check_res("result", e);
            end
        end
    end

    initial begin
        logic [31:0] v;
        vecs[0] = '{32'd0, 32'd1, 32'd50, 100, 50, 4, 1'b0,
                    32'd100, 32'd480, 32'd99, 32'd0, 32'd50};
        vecs[1] = '{32'd40, 32'd10, 32'd50, 2, 1, 20, 1'b0,
                    32'd2, 32'd24000, 32'd50, 32'd40, 32'd1};
        vecs[2] = '{32'd0, 32'd1, 32'd5, 10, 5, 4, 1'b0,
                    32'd10, 32'd4800, 32'd9, 32'd0, 32'd5};
        vecs[3] = '{32'd1000, 32'd3, 32'd1030, 30, 10, 2, 1'b0,
                    32'd30, 32'd1600, 32'd1087, 32'd1000, 32'd20};
        vecs[4] = '{32'd16, 32'd256, 32'd784, 8, 3, 5, 1'b1,
                    32'd8, 32'd6000, 32'd1808, 32'd16, 32'd5};
        none = mk(0, 0, 0, 0, 0, 1'b0);

        // Reset with enable held high.
        rst            = 1'b1;
        enable_i       = 1'b1;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        threshold_i    = '0;
        idle(2);
        check_res("reset", none);
        check("reset.result_valid", {31'd0, result_valid_o}, 32'd0);
        check("reset.busy", {31'd0, busy_o}, 32'd0);
        check("reset.overrun", {31'd0, overrun_o}, 32'd0);
        rst = 1'b0;

        // Periodic waves: first crossing arms, each later crossing yields a result.
        for (int r = 0; r < 5; r++) begin
            rearm(vecs[r].thr | (vecs[r].junk ? 32'h5A00_0000 : 32'h0));
            for (int rep = 0; rep <= 4; rep++) begin
                for (int i = 0; i < vecs[r].len; i++) begin
                    if (rep == 4 && i > vecs[r].ic) break;
                    v = vecs[r].lo + vecs[r].step * 32'(i);
                    if (vecs[r].junk) v = v | 32'hAB00_0000;
                    send(v, vecs[r].gap, (rep > 0) && (i == vecs[r].ic), 33,
                         mk(vecs[r].period, vecs[r].freq, vecs[r].peak, vecs[r].trough,
                            vecs[r].hc, 1'b0));
                end
            end
            idle(40);
        end

        // Timeout: one good result, then a flat zero signal.
        rearm(32'd5);
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 10; i++)
                send(32'(i), 4, (rep == 1) && (i == 5), 33, mk(10, 4800, 9, 0, 5, 1'b0));
        for (int j = 1; j <= 96; j++)
            send(32'd0, 1, j == 96, 1, mk(0, 0, 9, 0, 5, 1'b1));
        idle(3);
        check("timeout.no_signal_held", {31'd0, no_signal_o}, 32'd1);
        // Back in ARM: first crossing arms, second one publishes.
        for (int rep = 0; rep < 3; rep++)
            for (int i = 0; i < 10; i++) begin
                if (rep == 2 && i > 4) break;
                send(32'(i), 4, (rep == 1) && (i == 5), 33, mk(10, 4800, 9, 0, 5, 1'b0));
            end
        idle(40);
        check("timeout.no_signal_clear", {31'd0, no_signal_o}, 32'd0);

        // Overrun: crossings every 10 clk while the divider needs 32.
        rearm(32'd5);
        check("overrun.cleared", {31'd0, overrun_o}, 32'd0);
        for (int rep = 0; rep <= 5; rep++)
            for (int i = 0; i < 10; i++) begin
                if (rep == 5 && i > 5) break;
                send(32'(i), 1, (rep == 1 || rep == 5) && (i == 5), 33,
                     mk(10, 4800, 9, 0, 5, 1'b0));
            end
        idle(40);
        check("overrun.set", {31'd0, overrun_o}, 32'd1);
        enable_i = 1'b0;
        idle(2);
        check("overrun.held_disabled", {31'd0, overrun_o}, 32'd1);
        enable_i = 1'b1;
        idle(2);
        check("overrun.cleared_on_enable", {31'd0, overrun_o}, 32'd0);

        // Abort: drop enable 10 cycles into a divide.
        rearm(32'd10);
        for (int i = 0; i < 20; i++) send(32'(i), 2, 1'b0, 0, none);
        for (int i = 0; i < 10; i++) send(32'(i), 2, 1'b0, 0, none);
        send(32'd10, 1, 1'b0, 0, none);
        idle(9);
        @(negedge clk);
        check("abort.busy_before", {31'd0, busy_o}, 32'd1);
        enable_i = 1'b0;
        @(negedge clk);
        check("abort.busy_after", {31'd0, busy_o}, 32'd0);
        check_res("abort.hold", mk(10, 4800, 9, 0, 5, 1'b0));
        idle(40);
        check_res("abort.hold_late", mk(10, 4800, 9, 0, 5, 1'b0));

        // Reset in the middle of a divide.
        enable_i = 1'b1;
        idle(1);
        for (int i = 0; i < 20; i++) send(32'(i), 2, 1'b0, 0, none);
        for (int i = 0; i < 10; i++) send(32'(i), 2, 1'b0, 0, none);
        send(32'd10, 1, 1'b0, 0, none);
        idle(5);
        check("rst_mid.busy_before", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        idle(1);
        check_res("rst_mid", none);
        check("rst_mid.busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        idle(40);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_analyzer.md
Name: wave_analyzer

Overview:
- Receive-side counterpart of the signal generator. Consumes a stream of unsigned audio samples and measures, per waveform cycle:
  - period in samples
  - frequency in Hz, floor(SAMPLE_RATE/period)
  - peak and trough values
  - high-sample count (duty)
- Sits in the sig_gen IP loopback/verification path and is read by software through AXI registers.

Parameters:
- SAMPLE_RATE, 48000: sample rate in Hz; dividend for the frequency result.
- BIT_DEPTH, 24: meaningful LSBs of sample_i; upper bits ignored (treated as zero).
- MAX_PERIOD, 65535: timeout in samples; must be >= 64.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- enable_i, input, 1: 1 = analyze; 0 = idle and abort.
- sample_i, input, 32: unsigned sample; bits [BIT_DEPTH-1:0] used.
- sample_valid_i, input, 1: sample_i valid this cycle. No backpressure.
- threshold_i, input, 32: crossing threshold, compared on BIT_DEPTH bits.
- period_o, output, 32: samples per cycle of the last result.
- freq_o, output, 32: floor(SAMPLE_RATE/period_o) of the last result.
- peak_o, output, 32: maximum sample in the measured cycle.
- trough_o, output, 32: minimum sample in the measured cycle.
- high_cnt_o, output, 32: samples >= threshold in the measured cycle.
- result_valid_o, output, 1: one-cycle pulse when all result outputs update.
- busy_o, output, 1: divider running.
- no_signal_o, output, 1: last result was a timeout.
- overrun_o, output, 1: sticky; a completed cycle was dropped.

Behaviour:
- Reset: all outputs 0; state IDLE; divider idle; prev_above=1; all counters 0.
- above = (sample[BIT_DEPTH-1:0] >= threshold[BIT_DEPTH-1:0]); equality counts as above. prev_above updates only on sample_valid_i.
- Rising crossing = sample_valid_i & above & !prev_above. Because prev_above resets to 1, a stream that starts high needs a low sample before its first crossing.
- Main FSM:
  - IDLE: counters cleared. enable_i=1 -> ARM; on that transition overrun_o clears.
  - ARM: wait for a crossing. On crossing: cnt=1, peak=trough=sample, hc=1 -> MEASURE.
  - MEASURE, valid non-crossing sample: cnt+1; peak=max; trough=min; hc+=above.
  - MEASURE, crossing:
    - If divider idle: latch period=cnt, peak, trough, hc into the pending result and start the divider.
    - If divider busy: set overrun_o and discard the cycle.
    - In both cases, restart counters from the crossing sample (cnt=1 etc.).
  - MEASURE timeout: valid non-crossing sample with cnt==MAX_PERIOD ->
    - publish period_o=0, freq_o=0, peak_o/trough_o/high_cnt_o = running values;
    - no_signal_o=1; result_valid_o pulse next cycle;
    - -> ARM.
  - enable_i=0 in any state -> IDLE next cycle; divider aborted; no pulse; result outputs hold.
- Divider (DIV_IDLE/DIV_RUN): restoring, 1 quotient bit per cycle, 32 iterations.
  - Crossing accepted in cycle N -> iterations in N+1..N+32 (busy_o=1) -> all outputs update and result_valid_o=1 in N+33.
  - no_signal_o clears with that update.
- Publication rules:
  - The first crossing after arming yields no result; the first result follows the second crossing.
  - Pending result registers are isolated from the running counters, so measurement continues during the divide.
- Widths: counters 32-bit, saturating at MAX_PERIOD via the timeout. peak/trough hold zero-extended BIT_DEPTH values.
- rst mid-divide: immediate return to reset values; no pulse.

Test Plan:
- Reset: assert rst 2 cycles with enable_i=1 -> all outputs 0, busy_o=0, no result_valid_o pulse.
- Sawtooth 0..99 step 1, one valid per 4 clk, threshold=50 -> from the 2nd crossing, each pulse shows period_o=100, freq_o=480, peak_o=99, trough_o=0, high_cnt_o=50; pulse exactly 33 clk after the crossing sample.
- Threshold equality: sequence 40,50,40,50…, threshold=50 -> crossing on each 50; period_o=2, high_cnt_o=1, freq_o=24000.
- Overrun: 10-sample sawtooth, valid every clk -> first result published (period_o=10, freq_o=4800); crossings during busy_o set overrun_o=1 and are dropped; overrun_o holds until enable_i toggles 0->1.
- Timeout: MAX_PERIOD=100; after a valid result, hold sample=0 -> after 100 further valid samples, pulse with period_o=0, freq_o=0, no_signal_o=1; FSM in ARM; the next two crossings restore valid results with no_signal_o=0.
- Abort: drop enable_i at N+10 after a crossing -> no pulse, busy_o=0 next cycle, result outputs keep prior values.
